// File: rtl/lcd_cmd_host.sv
// Command-issuing host for LCD_CTRL: buffers a command list, then issues it one
// strobe at a time over the cmd/cmd_valid/busy handshake and reports done/timeout.
`timescale 1ns/1ps
module lcd_cmd_host #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned AW      = 6,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic          clk_i,
   input  logic          reset_ni,
   input  logic          load_en_i,
   input  logic [AW-1:0] load_addr_i,
   input  logic [2:0]    load_cmd_i,
   input  logic [AW:0]   num_cmd_i,
   input  logic          start_i,
   input  logic          busy_i,
   input  logic          done_i,
   output logic [2:0]    cmd_o,
   output logic          cmd_valid_o,
   output logic          run_busy_o,
   output logic          run_done_o,
   output logic          run_err_o,
   output logic [AW:0]   issued_cnt_o
);

   localparam int unsigned CW  = 3;
   localparam int unsigned NW  = AW + 1;
   localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_ISSUE, S_GAP, S_DRAIN, S_FIN
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  mem [DEPTH];
   logic [NW-1:0]  num_q, num_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic [CW-1:0]  cmd_q, cmd_d;
   logic           cmd_valid_q, cmd_valid_d;
   logic           run_busy_q, run_busy_d;
   logic           run_done_q, run_done_d;
   logic           run_err_q, run_err_d;
   logic [NW-1:0]  issued_q, issued_d;

   logic           wd_exp;
   logic [NW-1:0]  num_clamped;

   assign wd_exp      = (wd_q == WDW'(TIMEOUT - 1));
   assign num_clamped = (num_cmd_i > NW'(DEPTH)) ? NW'(DEPTH) : num_cmd_i;

   // Buffer writes only while idle so a running list cannot be corrupted
   always_ff @(posedge clk_i) begin
      if (state_q == S_IDLE && load_en_i) begin
         mem[load_addr_i] <= load_cmd_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = (num_clamped == '0) ? S_DRAIN : S_WAIT;
         S_WAIT:  if (!busy_i) state_d = S_ISSUE;
                  else if (wd_exp) state_d = S_FIN;
         S_ISSUE: state_d = S_GAP;
         S_GAP:   state_d = (issued_q == num_q) ? S_DRAIN : S_WAIT;
         S_DRAIN: if (done_i || wd_exp) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and run bookkeeping
   always_comb begin
      num_d       = num_q;
      rd_ptr_d    = rd_ptr_q;
      wd_d        = '0;
      cmd_d       = cmd_q;
      cmd_valid_d = 1'b0;
      run_busy_d  = run_busy_q;
      run_done_d  = run_done_q;
      run_err_d   = run_err_q;
      issued_d    = issued_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               num_d      = num_clamped;
               rd_ptr_d   = '0;
               issued_d   = '0;
               run_done_d = 1'b0;
               run_err_d  = 1'b0;
               run_busy_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (!busy_i) begin
               cmd_d       = mem[rd_ptr_q];
               cmd_valid_d = 1'b1;
            end else if (wd_exp) begin
               run_err_d = 1'b1;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         S_ISSUE: begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            issued_d = issued_q + NW'(1);
         end
         S_DRAIN: begin
            if (done_i) begin
               run_done_d = 1'b1;
            end else if (wd_exp) begin
               run_err_d = 1'b1;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         S_FIN: run_busy_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         num_q       <= '0;
         rd_ptr_q    <= '0;
         wd_q        <= '0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         run_busy_q  <= 1'b0;
         run_done_q  <= 1'b0;
         run_err_q   <= 1'b0;
         issued_q    <= '0;
      end else begin
         num_q       <= num_d;
         rd_ptr_q    <= rd_ptr_d;
         wd_q        <= wd_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         run_busy_q  <= run_busy_d;
         run_done_q  <= run_done_d;
         run_err_q   <= run_err_d;
         issued_q    <= issued_d;
      end
   end

   assign cmd_o        = cmd_q;
   assign cmd_valid_o  = cmd_valid_q;
   assign run_busy_o   = run_busy_q;
   assign run_done_o   = run_done_q;
   assign run_err_o    = run_err_q;
   assign issued_cnt_o = issued_q;

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed bench for lcd_cmd_host with a small LCD_CTRL busy model and a strobe monitor.
`timescale 1ns/1ps
module tb_lcd_cmd_host;

   localparam int unsigned AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [2:0]    load_cmd = '0;
   logic [AW:0]   num_cmd = '0;
   logic          start = 1'b0;
   logic          busy;
   logic          done = 1'b0;
   logic [2:0]    cmd;
   logic          cmd_valid;
   logic          run_busy;
   logic          run_done;
   logic          run_err;
   logic [AW:0]   issued_cnt;

   logic          busy_force = 1'b0;
   logic          model_en = 1'b0;
   int            mcnt = 0;

   int            total = 0;
   int            bad = 0;

   int            cyc = 0;
   int            last_cyc = 0;
   int            n_strobe = 0;
   int            viol = 0;
   logic          prev_busy = 1'b0;
   int            st_cyc [256];
   logic [2:0]    st_cmd [256];

   lcd_cmd_host #(.DEPTH(64), .AW(AW), .TIMEOUT(16)) dut (
      .clk_i(clk), .reset_ni(rst_n), .load_en_i(load_en), .load_addr_i(load_addr),
      .load_cmd_i(load_cmd), .num_cmd_i(num_cmd), .start_i(start), .busy_i(busy),
      .done_i(done), .cmd_o(cmd), .cmd_valid_o(cmd_valid), .run_busy_o(run_busy),
      .run_done_o(run_done), .run_err_o(run_err), .issued_cnt_o(issued_cnt)
   );

   always #5 clk = ~clk;

   assign busy = busy_force | (model_en & (mcnt != 0));

   // LCD_CTRL model (busy 5 cycles, starting 1 cycle after a strobe) and strobe monitor
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      prev_busy <= busy;
      if (cmd_valid) mcnt <= 5;
      else if (mcnt != 0) mcnt <= mcnt - 1;
      if (cmd_valid) begin
         viol <= viol + ((prev_busy) ? 1 : 0) + ((n_strobe > 0 && cyc - last_cyc < 3) ? 1 : 0);
         if (n_strobe < 256) begin
            st_cyc[n_strobe] <= cyc;
            st_cmd[n_strobe] <= cmd;
         end
         n_strobe <= n_strobe + 1;
         last_cyc <= cyc;
      end
   end

   function automatic logic [2:0] pat(input int i);
      pat = 3'((i * 3 + 1) & 7);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [2:0] c);
      load_en = 1'b1; load_addr = AW'(a); load_cmd = c;
      tick();
      load_en = 1'b0;
   endtask

   task automatic start_run(input int n);
      start = 1'b1; num_cmd = (AW+1)'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int i;
      i = 0;
      while (run_busy === 1'b1 && i < budget) begin
         tick();
         i++;
      end
      check(tag, 32'(run_busy), 32'd0);
   endtask

   initial begin
      int base;
      int errs;

      // Reset values
      tick(); tick();
      check("rst_cmd", 32'(cmd), 32'd0);
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_run_busy", 32'(run_busy), 32'd0);
      check("rst_run_done", 32'(run_done), 32'd0);
      check("rst_run_err", 32'(run_err), 32'd0);
      check("rst_issued", 32'(issued_cnt), 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic four-command run, busy never asserted, done held high throughout
      load(0, 3'd1); load(1, 3'd3); load(2, 3'd2); load(3, 3'd0);
      done = 1'b1;
      base = n_strobe;
      start_run(4);
      check("t1_run_busy", 32'(run_busy), 32'd1);
      wait_idle("t1_idle", 50);
      check("t1_nstrobe", 32'(n_strobe - base), 32'd4);
      check("t1_cmd0", 32'(st_cmd[base]), 32'd1);
      check("t1_cmd1", 32'(st_cmd[base+1]), 32'd3);
      check("t1_cmd2", 32'(st_cmd[base+2]), 32'd2);
      check("t1_cmd3", 32'(st_cmd[base+3]), 32'd0);
      check("t1_gap", 32'(st_cyc[base+3] - st_cyc[base]), 32'd9);
      check("t1_issued", 32'(issued_cnt), 32'd4);
      check("t1_run_done", 32'(run_done), 32'd1);
      check("t1_run_err", 32'(run_err), 32'd0);

      // 45-command stream against the busy model
      for (int i = 0; i < 45; i++) load(i, pat(i));
      model_en = 1'b1;
      base = n_strobe;
      start_run(45);
      wait_idle("t2_idle", 400);
      model_en = 1'b0;
      check("t2_nstrobe", 32'(n_strobe - base), 32'd45);
      errs = 0;
      for (int k = 1; k < 45; k++)
         if (st_cyc[base+k] - st_cyc[base+k-1] != 7) errs++;
      check("t2_spacing", 32'(errs), 32'd0);
      errs = 0;
      for (int k = 0; k < 45; k++)
         if (st_cmd[base+k] !== pat(k)) errs++;
      check("t2_cmds", 32'(errs), 32'd0);
      check("t2_issued", 32'(issued_cnt), 32'd45);
      check("t2_run_done", 32'(run_done), 32'd1);

      // Busy stuck high: timeout after 16 WAIT cycles
      done = 1'b0;
      busy_force = 1'b1;
      base = n_strobe;
      start_run(4);
      for (int i = 0; i < 15; i++) tick();
      check("t3_err_early", 32'(run_err), 32'd0);
      tick();
      check("t3_err", 32'(run_err), 32'd1);
      tick();
      check("t3_run_busy", 32'(run_busy), 32'd0);
      check("t3_run_done", 32'(run_done), 32'd0);
      check("t3_nstrobe", 32'(n_strobe - base), 32'd0);
      check("t3_issued", 32'(issued_cnt), 32'd0);
      busy_force = 1'b0;

      // Empty run
      done = 1'b1;
      base = n_strobe;
      start_run(0);
      tick();
      check("t4_run_done", 32'(run_done), 32'd1);
      check("t4_err_cleared", 32'(run_err), 32'd0);
      tick();
      check("t4_run_busy", 32'(run_busy), 32'd0);
      check("t4_nstrobe", 32'(n_strobe - base), 32'd0);

      // Reset during the ISSUE cycle
      done = 1'b0;
      start_run(4);
      tick();
      check("t5_issue_valid", 32'(cmd_valid), 32'd1);
      check("t5_issue_cmd", 32'(cmd), 32'(pat(0)));
      base = n_strobe;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(cmd_valid), 32'd0);
      check("t5_rst_cmd", 32'(cmd), 32'd0);
      check("t5_rst_run_busy", 32'(run_busy), 32'd0);
      check("t5_rst_done", 32'(run_done), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("t5_rst_strobe", 32'(n_strobe - base), 32'd0);
      // Fresh run, with a same-cycle load to entry 0
      done = 1'b1;
      load_en = 1'b1; load_addr = '0; load_cmd = 3'd5;
      start_run(2);
      load_en = 1'b0;
      wait_idle("t5_idle", 50);
      check("t5_nstrobe", 32'(n_strobe - base), 32'd2);
      check("t5_cmd0", 32'(st_cmd[base]), 32'd5);
      check("t5_cmd1", 32'(st_cmd[base+1]), 32'(pat(1)));
      check("t5_issued", 32'(issued_cnt), 32'd2);

      // load_en and start during a run are ignored
      model_en = 1'b1;
      base = n_strobe;
      start_run(3);
      for (int i = 0; i < 4; i++) tick();
      load_en = 1'b1; load_addr = '0; load_cmd = 3'd7;
      start_run(10);
      load_en = 1'b0;
      wait_idle("t6_idle", 100);
      model_en = 1'b0;
      check("t6_nstrobe", 32'(n_strobe - base), 32'd3);
      check("t6_issued", 32'(issued_cnt), 32'd3);
      base = n_strobe;
      start_run(1);
      wait_idle("t6b_idle", 50);
      check("t6b_nstrobe", 32'(n_strobe - base), 32'd1);
      check("t6b_buf0", 32'(st_cmd[base]), 32'd5);
      check("t6b_issued", 32'(issued_cnt), 32'd1);

      check("protocol_viol", 32'(viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_host.md
Name: lcd_cmd_host

Overview:
- Command-issuing host for LCD_CTRL: the initiator end of its cmd/cmd_valid/busy handshake.
- A command list is loaded into an internal buffer, then issued to LCD_CTRL one command at a time, each only when LCD_CTRL is not busy.
- Watches LCD_CTRL done and reports run completion or a busy-timeout.
- Replaces the bench-side command driver, so command streams can run on silicon/FPGA without a testbench.

Parameters:
DEPTH, 64, command buffer entries (power of 2)
AW, 6, buffer address width, log2(DEPTH)
TIMEOUT, 1024, max consecutive cycles busy may stay high before error

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
load_en  in  1  write load_cmd into buffer[load_addr]; ignored unless state IDLE
load_addr  in  AW  buffer write address
load_cmd  in  3  command code to store
num_cmd  in  AW+1  number of commands to issue, sampled on start; 0..DEPTH
start  in  1  begin run; accepted only in IDLE
busy  in  1  from LCD_CTRL; high = cannot accept command
done  in  1  from LCD_CTRL; run complete pulse/level
cmd  out  3  command to LCD_CTRL
cmd_valid  out  1  one-cycle command strobe
run_busy  out  1  high from start accept until run_done/run_err
run_done  out  1  sticky: LCD_CTRL done observed; cleared on next start
run_err  out  1  sticky: busy timeout; cleared on next start
issued_cnt  out  AW+1  commands issued this run

Behaviour:
- Reset (reset=0, async): state IDLE; cmd=0, cmd_valid=0, run_busy=0, run_done=0, run_err=0, issued_cnt=0, watchdog=0. Buffer contents are not reset.
- All outputs are registered. Command codes are opaque 3-bit values, passed through unmodified.
- States: IDLE, WAIT, ISSUE, GAP, DRAIN, FIN.
- IDLE:
  - load_en writes the buffer.
  - On start: latch num_cmd; clear rd_ptr, issued_cnt, run_done, run_err; set run_busy; go WAIT.
  - If num_cmd=0, go DRAIN instead of WAIT.
- WAIT:
  - busy=0: go ISSUE.
  - busy=1: increment watchdog; at watchdog==TIMEOUT-1, set run_err and go FIN.
  - Watchdog clears on every transition out of WAIT/DRAIN.
- ISSUE:
  - For exactly one cycle: cmd=buffer[rd_ptr], cmd_valid=1.
  - Increment rd_ptr and issued_cnt; go GAP.
- GAP:
  - One cycle with cmd_valid=0; busy is ignored, because LCD_CTRL's busy response to the strobe is not yet visible.
  - If issued_cnt==latched num_cmd, go DRAIN; else go WAIT.
- DRAIN:
  - Wait for done=1: set run_done, go FIN.
  - Timeout counts while done=0 using the same limit; expiry sets run_err.
- FIN: clear run_busy; return to IDLE next cycle. run_done/run_err hold until the next start.
- cmd holds the last issued value after the strobe; only cmd_valid qualifies it.
- Never two cmd_valid pulses less than 3 cycles apart; never cmd_valid while busy was sampled high.
- Ignored inputs:
  - start while run_busy is ignored.
  - load_en outside IDLE is ignored (no buffer corruption mid-run).
- Simultaneous events:
  - done seen before all commands are issued (WAIT/GAP): ignored; only done in DRAIN counts.
  - start and load_en in the same IDLE cycle: the write completes; the run starts and the first command read happens ≥2 cycles later, so it sees the new data.
- num_cmd > DEPTH is clamped to DEPTH. rd_ptr wraps naturally, never past num_cmd.
- Reset mid-run: immediate return to IDLE with outputs cleared; cmd_valid drops asynchronously.

Test Plan:
- Load buffer[0..3]={1,3,2,0}; start, num_cmd=4; busy=0 permanently; done asserted in DRAIN → cmd_valid pulses with cmd 1,3,2,0, one strobe per 3 cycles (ISSUE,GAP,WAIT); issued_cnt=4; run_done=1, run_busy=0.
- LCD_CTRL model raises busy 1 cycle after the strobe for 5 cycles → each next strobe occurs exactly 1 cycle after busy falls; no strobe while busy=1; the 45-command stream completes with issued_cnt=45.
- busy held high after start with TIMEOUT=16 → no cmd_valid; run_err=1 after 16 WAIT cycles; run_busy drops; run_done=0.
- num_cmd=0, done=1 → zero strobes; run_done=1 within 3 cycles.
- Reset pulled low during the ISSUE cycle → cmd_valid=0 immediately; all outputs 0; a fresh start reissues from buffer[0].
- load_en and start asserted during a run → buffer unchanged (verified by a later run); second start ignored; issued_cnt unaffected.
